// File: rtl/td4_pkg.sv
// Shared definitions for the TD4-class core: opcode encodings and sequencer states.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_ADD_B  = 4'b1010;
  localparam logic [3:0] OP_MOV_A  = 4'b1100;
  localparam logic [3:0] OP_MOV_B  = 4'b1110;
  localparam logic [3:0] OP_MOV_AB = 4'b1000;
  localparam logic [3:0] OP_MOV_BA = 4'b0010;
  localparam logic [3:0] OP_IN_A   = 4'b0100;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b0111;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STEP_WAIT  = 2'd1,
    ST_STEP_ARMED = 2'd2,
    ST_HALT       = 2'd3
  } state_e;

endpackage

// File: rtl/td4_alu.sv
// DW-bit adder shared by both ADD instructions; carry-out feeds the carry flag.
module td4_alu #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] sum,
  output logic          cout
);

  // Zero-extend both operands by one bit so the MSB of the result is the carry.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, imm};
  end

endmodule

// File: rtl/td4_core.sv
// TD4-class single-cycle CPU core with carry, IN/OUT, JMP/JNC, valid/ready fetch
// handshake, single-step sequencing and self-jump halt.
module td4_core
  import td4_pkg::*;
#(
  parameter int DW               = 4,
  parameter int AW               = 4,
  parameter int HALT_ON_SELF_JMP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] immediate,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [DW-1:0] io_input,
  input  logic          step_mode,
  input  logic          step_req,
  output logic [DW-1:0] regA_o,
  output logic [DW-1:0] regB_o,
  output logic [DW-1:0] regOut,
  output logic [AW-1:0] pc_out,
  output logic          carry,
  output logic          retire,
  output logic          halted
);

  state_e        state;
  logic          step_q;
  logic          step_edge;
  logic          fire;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_sum;
  logic          alu_cout;
  logic [AW-1:0] jmp_target;
  logic [AW-1:0] pc_inc;
  logic          jmp_taken;
  logic          halt_hit;

  // Immediate is zero-extended or truncated to the PC width for jumps.
  if (DW >= AW) begin : g_tgt_trunc
    assign jmp_target = immediate[AW-1:0];
  end else begin : g_tgt_ext
    assign jmp_target = {{(AW-DW){1'b0}}, immediate};
  end

  // Handshake, step edge, next-PC and halt decode.
  always_comb begin
    instr_ready = (state == ST_RUN) || (state == ST_STEP_ARMED);
    halted      = (state == ST_HALT);
    fire        = instr_valid && instr_ready;
    step_edge   = step_req && !step_q;
    pc_inc      = pc_out + AW'(1);
    alu_a       = (opcode == OP_ADD_B) ? regB_o : regA_o;
    jmp_taken   = fire && ((opcode == OP_JMP) || ((opcode == OP_JNC) && !carry));
    halt_hit    = jmp_taken && (jmp_target == pc_out) && (HALT_ON_SELF_JMP != 0);
  end

  td4_alu #(.DW(DW)) u_alu (
    .a    (alu_a),
    .imm  (immediate),
    .sum  (alu_sum),
    .cout (alu_cout)
  );

  // Architectural state: registers, carry, PC and the retire pulse update only on fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regA_o <= '0;
      regB_o <= '0;
      regOut <= '0;
      pc_out <= '0;
      carry  <= 1'b0;
      retire <= 1'b0;
    end else begin
      retire <= fire;
      if (fire) begin
        carry  <= 1'b0;
        pc_out <= jmp_taken ? jmp_target : pc_inc;
        case (opcode)
          OP_ADD_A: begin
            regA_o <= alu_sum;
            carry  <= alu_cout;
          end
          OP_ADD_B: begin
            regB_o <= alu_sum;
            carry  <= alu_cout;
          end
          OP_MOV_A:  regA_o <= immediate;
          OP_MOV_B:  regB_o <= immediate;
          OP_MOV_AB: regA_o <= regB_o;
          OP_MOV_BA: regB_o <= regA_o;
          OP_IN_A:   regA_o <= io_input;
          OP_IN_B:   regB_o <= io_input;
          OP_OUT_B:  regOut <= regB_o;
          OP_OUT_IM: regOut <= immediate;
          default:   ;
        endcase
      end
    end
  end

  // Run/step/halt sequencer; the step edge detector runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      step_q <= 1'b0;
    end else begin
      step_q <= step_req;
      case (state)
        ST_RUN: begin
          if (halt_hit)       state <= ST_HALT;
          else if (step_mode) state <= ST_STEP_WAIT;
        end
        ST_STEP_WAIT: begin
          if (!step_mode)     state <= ST_RUN;
          else if (step_edge) state <= ST_STEP_ARMED;
        end
        ST_STEP_ARMED: begin
          // Leaving step mode while armed goes straight to RUN, so the permit is not lost.
          if (halt_hit)        state <= ST_HALT;
          else if (!step_mode) state <= ST_RUN;
          else if (fire)       state <= ST_STEP_WAIT;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_core.sv
// Directed bench for td4_core: default, no-self-halt and wide (DW=8, AW=6) instances.
module tb_td4_core;

  localparam logic [3:0] ADDA = 4'b0000, ADDB = 4'b1010, MOVA = 4'b1100, MOVB = 4'b1110;
  localparam logic [3:0] MOVAB = 4'b1000, MOVBA = 4'b0010, INA = 4'b0100, INB = 4'b0110;
  localparam logic [3:0] OUTB = 4'b1001, OUTIM = 4'b1101, JNC = 4'b0111, JMP = 4'b1111;
  localparam logic [3:0] NOP = 4'b0011;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic [3:0] imm;
  logic [7:0] imm_w;
  logic       instr_valid;
  logic [3:0] io_in;
  logic       step_mode;
  logic       step_req;

  logic       rdy, c, ret, hlt;
  logic [3:0] a, b, o, pc;
  logic       rdy_n, c_n, ret_n, hlt_n;
  logic [3:0] a_n, b_n, o_n, pc_n;
  logic       rdy_w, c_w, ret_w, hlt_w;
  logic [7:0] a_w, b_w, o_w;
  logic [5:0] pc_w;

  int checks   = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  td4_core dut (
    .clk(clk), .rst(rst), .opcode(opcode), .immediate(imm), .instr_valid(instr_valid),
    .instr_ready(rdy), .io_input(io_in), .step_mode(step_mode), .step_req(step_req),
    .regA_o(a), .regB_o(b), .regOut(o), .pc_out(pc), .carry(c), .retire(ret), .halted(hlt)
  );

  td4_core #(.HALT_ON_SELF_JMP(0)) dut_nh (
    .clk(clk), .rst(rst), .opcode(opcode), .immediate(imm), .instr_valid(instr_valid),
    .instr_ready(rdy_n), .io_input(io_in), .step_mode(step_mode), .step_req(step_req),
    .regA_o(a_n), .regB_o(b_n), .regOut(o_n), .pc_out(pc_n), .carry(c_n), .retire(ret_n),
    .halted(hlt_n)
  );

  td4_core #(.DW(8), .AW(6)) dut_w (
    .clk(clk), .rst(rst), .opcode(opcode), .immediate(imm_w), .instr_valid(instr_valid),
    .instr_ready(rdy_w), .io_input({4'h0, io_in}), .step_mode(step_mode), .step_req(step_req),
    .regA_o(a_w), .regB_o(b_w), .regOut(o_w), .pc_out(pc_w), .carry(c_w), .retire(ret_w),
    .halted(hlt_w)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    step_mode   = 1'b0;
    step_req    = 1'b0;
    opcode      = NOP;
    imm         = '0;
    imm_w       = '0;
    io_in       = '0;
    rst         = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic exec(input logic [3:0] op, input logic [3:0] im, input logic [7:0] imw);
    opcode      = op;
    imm         = im;
    imm_w       = imw;
    instr_valid = 1'b1;
    tick();
  endtask

  task automatic count_retires(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (ret) cnt++;
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_out", o, 0);
    check("rst_pc", pc, 0);
    check("rst_carry", c, 0);
    check("rst_retire", ret, 0);
    check("rst_halted", hlt, 0);
    check("rst_ready", rdy, 1);

    // 1: ADD with and without carry-out, then MOV clears carry
    exec(ADDA, 4'd9, 8'd0);
    check("add9_a", a, 9);
    check("add9_c", c, 0);
    check("add9_retire", ret, 1);
    exec(ADDA, 4'd8, 8'd0);
    check("add8_a", a, 1);
    check("add8_c", c, 1);
    exec(MOVB, 4'd3, 8'd0);
    check("movb_b", b, 3);
    check("movb_c", c, 0);
    check("t1_pc", pc, 3);
    exec(ADDB, 4'd14, 8'd0);
    check("addb_b", b, 1);
    check("addb_c", c, 1);

    // 2: JNC not taken with carry set, taken when clear; JMP
    do_reset();
    exec(MOVA, 4'd1, 8'd0);
    exec(ADDA, 4'd15, 8'd0);
    check("t2_a", a, 0);
    check("t2_c", c, 1);
    exec(JNC, 4'd5, 8'd0);
    check("jnc_nt_pc", pc, 3);
    check("jnc_nt_c", c, 0);
    exec(MOVA, 4'd0, 8'd0);
    exec(JNC, 4'd5, 8'd0);
    check("jnc_t_pc", pc, 5);
    exec(JMP, 4'd2, 8'd0);
    check("jmp_pc", pc, 2);

    // No fire: state holds, no retire
    instr_valid = 1'b0;
    tick();
    tick();
    check("idle_pc", pc, 2);
    check("idle_retire", ret, 0);

    // 3: IN/OUT and PC wrap
    do_reset();
    io_in = 4'hA;
    exec(INA, 4'd0, 8'd0);
    check("ina_a", a, 4'hA);
    exec(MOVBA, 4'd0, 8'd0);
    exec(OUTB, 4'd0, 8'd0);
    check("outb_out", o, 4'hA);
    exec(OUTIM, 4'd6, 8'd0);
    check("outim_out", o, 6);
    io_in = 4'h5;
    exec(INB, 4'd0, 8'd0);
    check("inb_b", b, 5);
    exec(MOVAB, 4'd0, 8'd0);
    check("movab_a", a, 5);
    exec(JMP, 4'd15, 8'd0);
    check("pc15", pc, 15);
    exec(NOP, 4'd0, 8'd0);
    check("pc_wrap", pc, 0);

    // 4: single-step
    do_reset();
    step_mode = 1'b1;
    tick();
    tick();
    opcode      = NOP;
    instr_valid = 1'b1;
    cnt = 0;
    count_retires(10);
    check("step_idle_retires", cnt, 0);
    check("step_wait_ready", rdy, 0);
    cnt = 0;
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      tick();
      if (ret) cnt++;
      step_req = 1'b0;
      count_retires(3);
    end
    check("step3_retires", cnt, 3);
    check("step3_pc", pc, 3);
    cnt = 0;
    step_req = 1'b1;
    count_retires(20);
    check("step_hold_retires", cnt, 1);
    step_req  = 1'b0;
    step_mode = 1'b0;
    cnt = 0;
    count_retires(5);
    check("step_exit_retires", cnt, 4);
    check("step_exit_pc", pc, 8);

    // 5: self-jump halt vs. loop when disabled
    do_reset();
    exec(JMP, 4'd7, 8'd0);
    check("t5_pc7", pc, 7);
    exec(JMP, 4'd7, 8'd0);
    check("halt_flag", hlt, 1);
    check("halt_pc", pc, 7);
    check("halt_retire", ret, 1);
    check("halt_ready", rdy, 0);
    exec(MOVA, 4'd5, 8'd0);
    exec(MOVA, 4'd5, 8'd0);
    exec(MOVA, 4'd5, 8'd0);
    check("halt_a_hold", a, 0);
    check("halt_pc_hold", pc, 7);
    check("halt_no_retire", ret, 0);
    check("nh_halted", hlt_n, 0);
    check("nh_a", a_n, 5);
    check("nh_pc", pc_n, 10);

    // Non-taken JNC to its own address must not halt
    do_reset();
    exec(MOVA, 4'd15, 8'd0);
    exec(ADDA, 4'd1, 8'd0);
    exec(JNC, 4'd2, 8'd0);
    check("jnc_self_nt_halt", hlt, 0);
    check("jnc_self_nt_pc", pc, 3);

    // 6: async reset between edges
    do_reset();
    exec(MOVA, 4'd5, 8'd0);
    exec(MOVB, 4'd3, 8'd0);
    exec(ADDB, 4'd15, 8'd0);
    exec(OUTB, 4'd0, 8'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_a", a, 0);
    check("arst_b", b, 0);
    check("arst_out", o, 0);
    check("arst_pc", pc, 0);
    check("arst_carry", c, 0);
    check("arst_retire", ret, 0);

    // Wide instance DW=8, AW=6
    do_reset();
    exec(MOVA, 4'd0, 8'hF0);
    exec(ADDA, 4'd0, 8'h20);
    check("w_add_a", a_w, 8'h10);
    check("w_add_c", c_w, 1);
    exec(JMP, 4'd0, 8'h3F);
    check("w_jmp_pc", pc_w, 63);
    exec(NOP, 4'd0, 8'h00);
    check("w_wrap_pc", pc_w, 0);
    instr_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
